// File: rtl/sng_decoder.sv
// sng_decoder: stochastic-to-binary converter (receive end of the SNG encoder).
//
// Collects a BITSTREAM-bit stochastic word as BITSTREAM/LANES beats of LANES
// bits, counts the ones (s), and maps s back to a signed QUANT-bit value:
//   u = (s * 2^QUANT + BITSTREAM/2) >> log2(BITSTREAM)
//   q = u - 2^(QUANT-1), clamped high at 2^(QUANT-1)-1.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   iValid  in   input chunk valid
//   oReady  out  decoder can accept a chunk (ACCUM state)
//   iChunk  in   LANES stream bits, beat k = word bits [k*LANES +: LANES]
//   oValid  out  oData holds a decoded value (OUTPUT state)
//   iReady  in   downstream accepts oData
//   oData   out  signed decoded value
//   oSat    out  high-side clamp flag, only with SNG_DECODER_SAT_FLAG_EN
//
// Optional build macro: SNG_DECODER_SAT_FLAG_EN adds the oSat output.
//
// state  | meaning
// ACCUM  | accepting beats, accumulating ones count
// OUTPUT | holding decoded value until downstream takes it
module sng_decoder #(
    parameter int BITSTREAM = 64,
    parameter int LANES     = 8,
    parameter int QUANT     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [LANES-1:0] iChunk,
    output logic             oValid,
    input  logic             iReady,
    output logic [QUANT-1:0] oData
`ifdef SNG_DECODER_SAT_FLAG_EN
    ,
    output logic             oSat
`endif
);

    localparam int BEATS = BITSTREAM / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(BITSTREAM + 1);
    localparam int LOG2B = $clog2(BITSTREAM);
    localparam int UW    = CW + QUANT + 1;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [QUANT-1:0] data_q, data_d;

    logic [CW-1:0]    pop;
    logic [CW-1:0]    s_total;
    logic [UW-1:0]    num;
    logic [UW-1:0]    u;
    logic             sat;
    logic [QUANT-1:0] q_val;
    logic             last_beat;

`ifdef SNG_DECODER_SAT_FLAG_EN
    logic sat_q, sat_d;
`endif

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + CW'(iChunk[i]);
        end
    end

    // Full-width rounding divide; u never exceeds 2^QUANT, so any bit at or
    // above QUANT means the value hit the top end and must clamp.
    assign s_total = cnt_q + pop;
    assign num     = (UW'(s_total) << QUANT) + UW'(BITSTREAM / 2);
    assign u       = num >> LOG2B;
    assign sat     = |u[UW-1:QUANT];
    // Subtracting 2^(QUANT-1) from an in-range u only flips its top bit.
    assign q_val   = sat ? {1'b0, {(QUANT-1){1'b1}}}
                         : {~u[QUANT-1], u[QUANT-2:0]};

    assign last_beat = (beat_q == BW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        data_d  = data_q;
`ifdef SNG_DECODER_SAT_FLAG_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            ACCUM: begin
                if (iValid) begin
                    if (last_beat) begin
                        data_d  = q_val;
`ifdef SNG_DECODER_SAT_FLAG_EN
                        sat_d   = sat;
`endif
                        cnt_d   = '0;
                        beat_d  = '0;
                        state_d = OUTPUT;
                    end else begin
                        cnt_d  = s_total;
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            OUTPUT: begin
                if (iReady) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            beat_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
        end
    end

`ifdef SNG_DECODER_SAT_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
    assign oSat = sat_q;
`endif

    assign oReady = (state_q == ACCUM);
    assign oValid = (state_q == OUTPUT);
    assign oData  = data_q;

endmodule

// File: tb/tb_sng_decoder.sv
module tb_sng_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iValid;
    logic       oReady;
    logic [7:0] iChunk;
    logic       oValid;
    logic       iReady;
    logic [7:0] oData;
`ifdef SNG_DECODER_SAT_FLAG_EN
    logic       oSat;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sng_decoder #(.BITSTREAM(64), .LANES(8), .QUANT(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iValid (iValid),
        .oReady (oReady),
        .iChunk (iChunk),
        .oValid (oValid),
        .iReady (iReady),
        .oData  (oData)
`ifdef SNG_DECODER_SAT_FLAG_EN
        ,
        .oSat   (oSat)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: fraction of ones s/64 scaled to 256 levels, rounded, centred.
    function automatic int model_q(input int s);
        int v;
        v = (s * 256 + 32) / 64 - 128;
        if (v > 127) v = 127;
        return v;
    endfunction

    function automatic logic model_sat(input int s);
        return ((s * 256 + 32) / 64 - 128) > 127;
    endfunction

    // Low-discrepancy SNG encoder: ones count = round((q+128)/4), spread by
    // a stride-17 permutation of the 64 positions.
    function automatic logic [63:0] encode(input int q);
        logic [63:0] w;
        int t;
        t = (q + 128 + 2) / 4;
        for (int i = 0; i < 64; i++) w[i] = ((2 + 17 * i) % 64) < t;
        return w;
    endfunction

    task automatic run_frame(input logic [63:0] w, input int gap_at, input int gap_len,
                             input int hold, input string tag, output int got);
        int s;
        logic [7:0] exp;
        s   = $countones(w);
        exp = 8'(model_q(s));
        for (int k = 0; k < 8; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    iValid = 1'b0;
                    iChunk = 8'($urandom);
                    iReady = 1'($urandom);
                    @(negedge clk);
                end
            end
            iValid = 1'b1;
            iChunk = w[k*8 +: 8];
            iReady = 1'($urandom);
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(oValid), 32'd1);
        check({tag, "_data"}, 32'(oData), 32'(exp));
`ifdef SNG_DECODER_SAT_FLAG_EN
        check({tag, "_sat"}, 32'(oSat), 32'(model_sat(s)));
`endif
        got = int'($signed(oData));
        for (int h = 0; h < hold; h++) begin
            iValid = 1'($urandom);
            iChunk = 8'($urandom);
            iReady = 1'b0;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(oValid), 32'd1);
            check({tag, "_hold_data"}, 32'(oData), 32'(exp));
            check({tag, "_hold_ready"}, 32'(oReady), 32'd0);
        end
        iValid = 1'b0;
        iReady = 1'b1;
        @(negedge clk);
        check({tag, "_drain_valid"}, 32'(oValid), 32'd0);
        check({tag, "_drain_ready"}, 32'(oReady), 32'd1);
        iReady = 1'b0;
    endtask

    initial begin
        logic [63:0] w;
        int got;
        int diff;

        rst_n  = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        iChunk = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_ready", 32'(oReady), 32'd1);
        check("rst_data", 32'(oData), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // all zeros -> -128, all ones -> clamped 127
        run_frame(64'h0, -1, 0, 0, "zeros", got);
        check("zeros_val", 32'(got), 32'(-128));
        run_frame({64{1'b1}}, -1, 0, 0, "ones", got);
        check("ones_val", 32'(got), 32'd127);

        // 32 ones -> 0, 33 ones -> 4
        run_frame(64'h00FF_00FF_00FF_00FF, -1, 0, 0, "half", got);
        check("half_val", 32'(got), 32'd0);
        run_frame(64'h00FF_00FF_01FF_00FF, -1, 0, 0, "half1", got);
        check("half1_val", 32'(got), 32'd4);

        // gaps between beats 2 and 3, then 5 cycles of backpressure
        run_frame(64'h0F0F_3355_A5C3_7E81, 3, 3, 5, "gap_bp", got);

        // reset mid-frame discards partial count
        for (int k = 0; k < 3; k++) begin
            iValid = 1'b1;
            iChunk = 8'hFF;
            @(negedge clk);
        end
        iValid = 1'b0;
        rst_n  = 1'b0;
        #2;
        check("mid_rst_valid", 32'(oValid), 32'd0);
        check("mid_rst_ready", 32'(oReady), 32'd1);
        check("mid_rst_data", 32'(oData), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame({8{8'h03}}, -1, 0, 0, "post_rst", got);
        check("post_rst_val", 32'(got), 32'(-64));

        // random frames with random density, gaps and backpressure
        for (int r = 0; r < 24; r++) begin
            w = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0: w = w & {$urandom, $urandom};
                1: w = w | {$urandom, $urandom};
                default: ;
            endcase
            run_frame(w, $urandom_range(0, 8), $urandom_range(0, 3),
                      $urandom_range(0, 4), "rand", got);
        end

        // round trip through the encoder model
        for (int q = -128; q < 128; q++) begin
            run_frame(encode(q), $urandom_range(0, 8), $urandom_range(0, 1),
                      $urandom_range(0, 1), "rt", got);
            diff = got - q;
            check("rt_err_le4", 32'((diff <= 4) && (diff >= -4)), 32'd1);
            if (q == -1) check("rt_qm1", 32'(got), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
